dmem_lsu: RTL and testbench

- M-stage data-memory responder for the 5-stage RV32I pipeline.
- Consumes the controller's M-stage memory controls (MemWriteM, functM) plus the datapath address and store data.
- Performs byte/half/word stores with byte enables. Returns loads, sign- or zero-extended per funct3, as a registered W-stage value (ReadDataW) for the result mux.
- Flags misaligned and illegal accesses to the hazard/trap logic.

---
 rtl/rv_mem_pkg.sv | 32 +++
 rtl/load_extend.sv | 33 +++
 rtl/dmem_lsu.sv | 100 ++++++++++
 tb/tb_dmem_lsu.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared memory-access definitions for the RV32I pipeline: funct3 codes,
// lane width and access-legality helpers used by the LSU and future caches.
package rv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int BE_W = 4;

   localparam logic [1:0] RS_MEM = 2'b01;

   function automatic logic is_store_f3(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W};
   endfunction

   function automatic logic is_load_f3(input logic [2:0] f3);
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   // funct3[1:0] carries the access size for every legal encoding
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a 32-bit word and sign- or zero-extends
// it according to the load funct3.
module load_extend
   import rv_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] ext32
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign shifted  = word >> {off, 3'b000};
   assign byte_sel = shifted[7:0];
   assign half_sel = off[1] ? word[31:16] : word[15:0];

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves ext32 unassigned (no latch).
      ext32 = '0;
      case (funct3)
         F3_B:    ext32 = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ext32 = {24'h0, byte_sel};
         F3_H:    ext32 = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ext32 = {16'h0, half_sel};
         F3_W:    ext32 = word;
         default: ext32 = '0;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// M-stage data-memory responder: byte-enabled stores, registered extended loads
// into W, and misalign/illegal fault reporting with a sticky flag and counter.
module dmem_lsu
   import rv_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic        LoadM,
   input  logic [2:0]  functM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataW,
   output logic        MisalignW,
   output logic        IllegalW,
   output logic        FaultSticky,
   output logic [7:0]  FaultCount
);

   logic [31:0] mem [DEPTH_WORDS];

   logic [IDX_W-1:0] idx;
   logic [1:0]       off;
   logic             unused_addr_hi;
   logic             req, illegal, misalign, do_store, fault;
   logic [BE_W-1:0]  be;
   logic [31:0]      wdata;
   logic [31:0]      ld_ext;

   assign idx            = ALUResultM[IDX_W+1:2];
   assign off            = ALUResultM[1:0];
   assign unused_addr_hi = ^ALUResultM[31:IDX_W+2];

   assign req      = MemWriteM | LoadM;
   assign illegal  = (MemWriteM & ~is_store_f3(functM))
                   | (LoadM & ~is_load_f3(functM))
                   | (MemWriteM & LoadM);
   // Illegal takes priority over misaligned when both apply
   assign misalign = req & ~illegal & is_misaligned(functM, off);
   assign fault    = misalign | illegal;

   // A load/store conflict still lets a legal, aligned store go through
   assign do_store = MemWriteM & is_store_f3(functM) & ~is_misaligned(functM, off);

   always_comb begin
      be    = '0;
      wdata = WriteDataM;
      case (functM)
         F3_B: begin
            be    = 4'b0001 << off;
            wdata = {4{WriteDataM[7:0]}};
         end
         F3_H: begin
            be    = 4'b0011 << off;
            wdata = {2{WriteDataM[15:0]}};
         end
         F3_W:    be = 4'b1111;
         default: be = '0;
      endcase
   end

   // NOTE: the storage array has no reset; its contents survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (do_store) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   load_extend u_load_extend (
      .word   (mem[idx]),
      .off    (off),
      .funct3 (functM),
      .ext32  (ld_ext)
   );

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ReadDataW   <= '0;
         MisalignW   <= 1'b0;
         IllegalW    <= 1'b0;
         FaultSticky <= 1'b0;
         FaultCount  <= '0;
      end else begin
         MisalignW <= misalign;
         IllegalW  <= illegal;
         if (LoadM) ReadDataW <= fault ? 32'h0 : ld_ext;
         if (fault) begin
            FaultSticky <= 1'b1;
            if (FaultCount != 8'hFF) FaultCount <= FaultCount + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: vector table driven through a scoreboard,
// then fault-counter saturation and an asynchronous reset mid-sequence.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWriteM, LoadM;
   logic [2:0]  functM;
   logic [31:0] ALUResultM, WriteDataM;
   logic [31:0] ReadDataW;
   logic        MisalignW, IllegalW, FaultSticky;
   logic [7:0]  FaultCount;

   dmem_lsu dut (
      .clk         (clk),
      .reset       (reset),
      .MemWriteM   (MemWriteM),
      .LoadM       (LoadM),
      .functM      (functM),
      .ALUResultM  (ALUResultM),
      .WriteDataM  (WriteDataM),
      .ReadDataW   (ReadDataW),
      .MisalignW   (MisalignW),
      .IllegalW    (IllegalW),
      .FaultSticky (FaultSticky),
      .FaultCount  (FaultCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        ld;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        rd_upd;   // 0: ReadDataW is expected to hold
      logic [31:0] rd;
      logic        mis;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic        mis;
      logic        ill;
      logic        sticky;
      logic [7:0]  count;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_rd     = '0;
   logic        m_sticky = 1'b0;
   logic [7:0]  m_count  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic ld, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic rd_upd, input logic [31:0] rd,
                               input logic mis, input logic ill);
      vec_t v;
      v.we = we; v.ld = ld; v.f3 = f3; v.addr = addr; v.wd = wd;
      v.rd_upd = rd_upd; v.rd = rd; v.mis = mis; v.ill = ill;
      return v;
   endfunction

   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      MemWriteM  = v.we;
      LoadM      = v.ld;
      functM     = v.f3;
      ALUResultM = v.addr;
      WriteDataM = v.wd;
      if (v.rd_upd) m_rd = v.rd;
      if (v.mis || v.ill) begin
         m_sticky = 1'b1;
         if (m_count != 8'hFF) m_count++;
      end
      sb.push_back('{m_rd, v.mis, v.ill, m_sticky, m_count});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({tag, " ReadDataW"},   ReadDataW,          e.rd);
         check({tag, " MisalignW"},   {31'd0, MisalignW},  {31'd0, e.mis});
         check({tag, " IllegalW"},    {31'd0, IllegalW},   {31'd0, e.ill});
         check({tag, " FaultSticky"}, {31'd0, FaultSticky}, {31'd0, e.sticky});
         check({tag, " FaultCount"},  {24'd0, FaultCount}, {24'd0, e.count});
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " ReadDataW"},   ReadDataW,            32'd0);
      check({tag, " MisalignW"},   {31'd0, MisalignW},   32'd0);
      check({tag, " IllegalW"},    {31'd0, IllegalW},    32'd0);
      check({tag, " FaultSticky"}, {31'd0, FaultSticky}, 32'd0);
      check({tag, " FaultCount"},  {24'd0, FaultCount},  32'd0);
   endtask

   initial begin
      //             we ld f3      addr         wd            upd rd            mis  ill
      vecs.push_back(mk(1, 0, 3'b010, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0, 0));
      vecs.push_back(mk(1, 0, 3'b000, 32'h13,   32'h00000080, 0, 32'h0,        0, 0));
      vecs.push_back(mk(0, 1, 3'b000, 32'h13,   32'h0,        1, 32'hFFFFFF80, 0, 0));
      vecs.push_back(mk(0, 1, 3'b100, 32'h13,   32'h0,        1, 32'h00000080, 0, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h10,   32'h0,        1, 32'h80ADBEEF, 0, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h20,   32'h11223344, 0, 32'h0,        0, 0));
      vecs.push_back(mk(1, 0, 3'b001, 32'h22,   32'h77778001, 0, 32'h0,        0, 0));
      vecs.push_back(mk(0, 1, 3'b001, 32'h22,   32'h0,        1, 32'hFFFF8001, 0, 0));
      vecs.push_back(mk(0, 1, 3'b101, 32'h22,   32'h0,        1, 32'h00008001, 0, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h20,   32'h0,        1, 32'h80013344, 0, 0));
      vecs.push_back(mk(0, 1, 3'b001, 32'h20,   32'h0,        1, 32'h00003344, 0, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h11,   32'h0,        1, 32'h0,        1, 0));
      vecs.push_back(mk(1, 0, 3'b010, 32'h12,   32'hCAFEF00D, 0, 32'h0,        1, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h10,   32'h0,        1, 32'h80ADBEEF, 0, 0));
      vecs.push_back(mk(0, 1, 3'b001, 32'h21,   32'h0,        1, 32'h0,        1, 0));
      vecs.push_back(mk(0, 1, 3'b000, 32'h11,   32'h0,        1, 32'hFFFFFFBE, 0, 0));
      vecs.push_back(mk(0, 1, 3'b011, 32'h10,   32'h0,        1, 32'h0,        0, 1));
      vecs.push_back(mk(1, 0, 3'b100, 32'h10,   32'h01020304, 0, 32'h0,        0, 1));
      vecs.push_back(mk(1, 1, 3'b010, 32'h30,   32'h00001234, 1, 32'h0,        0, 1));
      vecs.push_back(mk(0, 1, 3'b010, 32'h30,   32'h0,        1, 32'h00001234, 0, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h10,   32'h0,        1, 32'h80ADBEEF, 0, 0));
      vecs.push_back(mk(0, 0, 3'b010, 32'h11,   32'h0,        0, 32'h0,        0, 0));
      vecs.push_back(mk(0, 1, 3'b111, 32'h13,   32'h0,        1, 32'h0,        0, 1));
      vecs.push_back(mk(1, 0, 3'b101, 32'h11,   32'hFFFFFFFF, 0, 32'h0,        0, 1));
      vecs.push_back(mk(0, 1, 3'b010, 32'h1010, 32'h0,        1, 32'h80ADBEEF, 0, 0));
      vecs.push_back(mk(1, 0, 3'b000, 32'h31,   32'hFFFFFFAB, 0, 32'h0,        0, 0));
      vecs.push_back(mk(0, 1, 3'b010, 32'h30,   32'h0,        1, 32'h0000AB34, 0, 0));
      vecs.push_back(mk(0, 1, 3'b110, 32'h30,   32'h0,        1, 32'h0,        0, 1));
      vecs.push_back(mk(0, 1, 3'b010, 32'h30,   32'h0,        1, 32'h0000AB34, 0, 0));

      reset      = 1'b1;
      MemWriteM  = 1'b0;
      LoadM      = 1'b0;
      functM     = 3'b000;
      ALUResultM = '0;
      WriteDataM = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 300; i++)
         apply(mk(0, 1, 3'b010, 32'h11, 32'h0, 1, 32'h0, 1, 0), "sat");

      apply(mk(1, 0, 3'b010, 32'h40, 32'h55AA55AA, 0, 32'h0, 0, 0), "pre_rst_sw");
      apply(mk(0, 1, 3'b010, 32'h11, 32'h0, 1, 32'h0, 1, 0), "pre_rst_mis");

      // Reset asserted mid-cycle with a load in flight; outputs must clear at once
      @(negedge clk);
      MemWriteM  = 1'b0;
      LoadM      = 1'b1;
      functM     = 3'b010;
      ALUResultM = 32'h10;
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      check_all_zero("rst_held");
      @(negedge clk);
      reset     = 1'b0;
      LoadM     = 1'b0;
      sb.delete();
      m_rd      = '0;
      m_sticky  = 1'b0;
      m_count   = '0;

      apply(mk(0, 1, 3'b010, 32'h10, 32'h0, 1, 32'h80ADBEEF, 0, 0), "post_rst_10");
      apply(mk(0, 1, 3'b010, 32'h30, 32'h0, 1, 32'h0000AB34, 0, 0), "post_rst_30");
      apply(mk(0, 1, 3'b010, 32'h40, 32'h0, 1, 32'h55AA55AA, 0, 0), "post_rst_40");
      apply(mk(0, 1, 3'b001, 32'h43, 32'h0, 1, 32'h0,        1, 0), "post_rst_mis");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
